riscv_exu_issue: RTL and testbench
==================================

# riscv_exu_issue

Parametrised issue stage for the execute unit. Takes the decoded instruction (`idu_vld` plus operand/destination fields and a unit-class one-hot) and checks source-operand hazards against `register_locked`. Selects a free execute port of the matching class, round-robin among eligible ports, then drives that port's `vld`, the destination lock and `hold`. Sits between the decode unit and the PORTS functional units (ALU, MUL/DIV, LSU, ...), replacing the single-ALU fixed dispatch of the previous execute unit.

## Interface
- `PORTS`, 2: number of execute ports; equals `riscv_pkg::REGISTER_PORTS` at instantiation.
- `CLASSES`, 2: number of unit classes (bit 0 ALU, bit 1 MUL/DIV, further bits as added).
- `PORT_CLASS`, `{PORTS{CLASSES'(1)}}`: packed `[PORTS-1:0][CLASSES-1:0]`; bit c of entry p set means port p executes class c.

- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `idu_vld`  in  1  decoded instruction valid; held stable by decode while `hold`=1.
- `idu_class`  in  CLASSES  one-hot unit class of the instruction.
- `idu_rs1`, `idu_rs2`, `idu_rd`  in  5 each  register indices.
- `idu_rs1_used`, `idu_rs2_used`, `idu_rd_used`  in  1 each  operand/destination valid.
- `register_locked`  in  32  per-register pending-write flags from the register file.
- `unit_done`  in  PORTS  port p finishes its instruction this cycle (one-cycle pulse).
- `unit_vld`  out  PORTS  one-hot issue strobe; at most one bit set.
- `register_lock_en`  out  PORTS  lock request on port p (coincides with `unit_vld[p]`).
- `register_lock`  out  PORTS×5  register to lock per port.
- `hold`  out  1  stall decode; instruction not accepted this cycle.
- `unit_busy`  out  PORTS  registered per-port occupancy.
- `stall_count`  out  32  saturating count of stalled cycles.

## Operation
- Hazard: `raw = (rs1_used & rs1≠0 & locked[rs1]) | (rs2_used & rs2≠0 & locked[rs2])`. Register x0 never hazards and is never locked.
- Eligible port p: `(PORT_CLASS[p] & idu_class) ≠ 0` and (`~unit_busy[p]` or `unit_done[p]`). A port is therefore reusable in its done cycle.
- Selection: the first eligible port at or after `rr_ptr`, wrapping modulo PORTS.
- Issue when `idu_vld & ~raw & ~waw & any_eligible`:
  - set `unit_vld[sel]`;
  - if `rd_used & rd≠0`, assert `register_lock_en[sel]` and drive `register_lock[sel]=rd`;
  - `hold=0`.
- Otherwise with `idu_vld=1`: `hold=1` and all `unit_vld=0`.
- With `idu_vld=0`: `hold=0` and all strobes 0.
- `idu_class` of zero or with no matching port: permanent hold. This is a decode error; the assertion `$onehot(idu_class)` applies when `idu_vld`.
- Registered state:
  - `unit_busy[p]` next = `unit_vld[p] | (unit_busy[p] & ~unit_done[p])`.
  - `rr_ptr` next = sel+1 mod PORTS on issue, else unchanged.
  - `stall_count` increments on `idu_vld & hold` and saturates at 0xFFFF_FFFF.
- `unit_done[p]` while `~unit_busy[p]` is ignored, and covered by an assertion.

## Timing
- Issue decision, `unit_vld`, lock and `hold` are combinational from inputs and registered state; zero-cycle issue latency.
- Lock is applied by the register file at the issue edge, so `register_locked` already reflects it the following cycle. Back-to-back dependent instructions therefore hold at least one cycle.
- Done and issue on the same port in the same cycle: `unit_busy` stays 1.
- Reset (sync, high) while `reset`=1:
  - `unit_busy=0`, `rr_ptr=0`, `stall_count=0`;
  - combinational outputs are forced `unit_vld=0`, `register_lock_en=0`, `hold=0`.
- Reset mid-operation abandons in-flight ports without a done. Units and the register file reset on the same edge.

## Configuration
- `RISCV_EXU_ISSUE_WAW_EN` defined: `waw = rd_used & rd≠0 & locked[rd]`, so an instruction whose destination is still pending holds. This guarantees in-order writeback across ports of differing latency.
- Not defined: `waw=0`. An instruction overwriting a pending register issues, and the register file last-writer rules apply.

## Test plan
- Reset, then `idu_vld=1`, class ALU, rd=5, no locks → cycle 0: `unit_vld=01`, lock_en[0]=1, lock=5, hold=0; next cycle `unit_busy=01`, rr_ptr=1.
- PORTS=2 both ALU, three independent ALU ops back-to-back, no done → issue on port 0, then port 1, then hold; `stall_count` increments by 1 per held cycle. `unit_done[0]` pulse → port 0 issues in that same cycle.
- rs1=7 with `register_locked[7]=1` for 3 cycles → hold 3 cycles with `unit_vld=0`, issue in the cycle lock clears. rs2=0 with `locked[0]` forced 1 → no hold.
- `PORT_CLASS={10,01}`, MUL/DIV op while port 1 busy and port 0 free → hold until `unit_done[1]`, then `unit_vld=10`.
- rd=9 locked, sources free: with `RISCV_EXU_ISSUE_WAW_EN` → hold; without → immediate issue with lock on 9.
- Assert reset for one cycle while both ports busy and `idu_vld=1` → outputs 0 during reset; afterwards `unit_busy=00`, `stall_count=0`, and the next instruction issues on port 0.

Source files
------------

// File: rtl/riscv_exu_issue_if.sv
// Issue-stage bundle between decode/register file/units and riscv_exu_issue.
// master: environment side (decode, register file, functional units).
// slave:  the issue stage itself.
interface riscv_exu_issue_if #(
    parameter int unsigned PORTS   = 2,
    parameter int unsigned CLASSES = 2
);
    logic                    idu_vld;
    logic [CLASSES-1:0]      idu_class;
    logic [4:0]              idu_rs1;
    logic [4:0]              idu_rs2;
    logic [4:0]              idu_rd;
    logic                    idu_rs1_used;
    logic                    idu_rs2_used;
    logic                    idu_rd_used;
    logic [31:0]             register_locked;
    logic [PORTS-1:0]        unit_done;
    logic [PORTS-1:0]        unit_vld;
    logic [PORTS-1:0]        register_lock_en;
    logic [PORTS-1:0][4:0]   register_lock;
    logic                    hold;
    logic [PORTS-1:0]        unit_busy;
    logic [31:0]             stall_count;

    modport master (
        output idu_vld, idu_class, idu_rs1, idu_rs2, idu_rd,
               idu_rs1_used, idu_rs2_used, idu_rd_used, register_locked, unit_done,
        input  unit_vld, register_lock_en, register_lock, hold, unit_busy, stall_count
    );

    modport slave (
        input  idu_vld, idu_class, idu_rs1, idu_rs2, idu_rd,
               idu_rs1_used, idu_rs2_used, idu_rd_used, register_locked, unit_done,
        output unit_vld, register_lock_en, register_lock, hold, unit_busy, stall_count
    );
endinterface

// File: rtl/riscv_exu_issue.sv
// Execute-unit issue stage: hazard check against register_locked, round-robin
// selection of a free port of the instruction's class, zero-latency issue.
// Optional feature macro: RISCV_EXU_ISSUE_WAW_EN (stall on pending destination).
module riscv_exu_issue #(
    parameter int unsigned PORTS   = 2,
    parameter int unsigned CLASSES = 2,
    parameter logic [PORTS-1:0][CLASSES-1:0] PORT_CLASS = {PORTS{CLASSES'(1)}}
) (
    input  logic              clock,
    input  logic              reset,
    riscv_exu_issue_if.slave  bus
);
    localparam int unsigned PtrW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0] busy;
    logic [PtrW-1:0]  rr_ptr;
    logic [31:0]      stall_count;

    logic             raw;
    logic             waw;
    logic [PORTS-1:0] eligible;
    logic             found;
    logic [PtrW-1:0]  sel;
    logic             issue;
    logic             hold;
    logic [PORTS-1:0] unit_vld;
    logic [PORTS-1:0] lock_en;
    logic [PORTS-1:0][4:0] lock;

    // Source and destination hazards; x0 never hazards.
    always_comb begin
        raw = (bus.idu_rs1_used && (bus.idu_rs1 != 5'd0) && bus.register_locked[bus.idu_rs1])
           || (bus.idu_rs2_used && (bus.idu_rs2 != 5'd0) && bus.register_locked[bus.idu_rs2]);
`ifdef RISCV_EXU_ISSUE_WAW_EN
        waw = bus.idu_rd_used && (bus.idu_rd != 5'd0) && bus.register_locked[bus.idu_rd];
`else
        waw = 1'b0;
`endif
    end

    // A port is eligible if it serves the class and is free or finishing now.
    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            eligible[p] = ((PORT_CLASS[p] & bus.idu_class) != '0)
                       && (!busy[p] || bus.unit_done[p]);
        end
    end

    // First eligible port at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            logic [PtrW-1:0] cand;
            cand = PtrW'((32'(rr_ptr) + i) % PORTS);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Issue strobes, lock request and decode stall; all quiet during reset.
    always_comb begin
        issue    = bus.idu_vld && !raw && !waw && found && !reset;
        hold     = bus.idu_vld && !issue && !reset;
        unit_vld = '0;
        lock_en  = '0;
        lock     = '0;
        if (issue) begin
            unit_vld[sel] = 1'b1;
            if (bus.idu_rd_used && (bus.idu_rd != 5'd0)) begin
                lock_en[sel] = 1'b1;
                lock[sel]    = bus.idu_rd;
            end
        end
    end

    // Port occupancy, round-robin pointer and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy        <= '0;
            rr_ptr      <= '0;
            stall_count <= '0;
        end else begin
            busy <= unit_vld | (busy & ~bus.unit_done);
            if (issue) begin
                rr_ptr <= (32'(sel) == PORTS - 1) ? '0 : sel + PtrW'(1);
            end
            if (hold && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    assign bus.unit_vld         = unit_vld;
    assign bus.register_lock_en = lock_en;
    assign bus.register_lock    = lock;
    assign bus.hold             = hold;
    assign bus.unit_busy        = busy;
    assign bus.stall_count      = stall_count;

    // Decode must present a one-hot class with a valid instruction.
    a_class_onehot: assert property (@(posedge clock) disable iff (reset)
        bus.idu_vld |-> $onehot(bus.idu_class));

    // Units only report done while occupied.
    a_done_busy: assert property (@(posedge clock) disable iff (reset)
        (bus.unit_done & ~busy) == '0);
endmodule

// File: tb/tb_riscv_exu_issue.sv
// Directed bench for riscv_exu_issue. Instance A: two ALU ports.
// Instance B: port 0 ALU, port 1 MUL/DIV.
module tb_riscv_exu_issue;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    riscv_exu_issue_if #(.PORTS(2), .CLASSES(2)) bus_a ();
    riscv_exu_issue_if #(.PORTS(2), .CLASSES(2)) bus_b ();

    riscv_exu_issue #(.PORTS(2), .CLASSES(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    riscv_exu_issue #(.PORTS(2), .CLASSES(2), .PORT_CLASS({2'b10, 2'b01})) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic op_a(input logic vld, input logic [1:0] cls,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic ud);
        bus_a.idu_vld      = vld;
        bus_a.idu_class    = cls;
        bus_a.idu_rs1      = rs1;
        bus_a.idu_rs1_used = u1;
        bus_a.idu_rs2      = rs2;
        bus_a.idu_rs2_used = u2;
        bus_a.idu_rd       = rd;
        bus_a.idu_rd_used  = ud;
    endtask

    task automatic op_b(input logic vld, input logic [1:0] cls, input logic [4:0] rd);
        bus_b.idu_vld      = vld;
        bus_b.idu_class    = cls;
        bus_b.idu_rs1      = 5'd0;
        bus_b.idu_rs1_used = 1'b0;
        bus_b.idu_rs2      = 5'd0;
        bus_b.idu_rs2_used = 1'b0;
        bus_b.idu_rd       = rd;
        bus_b.idu_rd_used  = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        op_a(1'b0, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        op_b(1'b0, 2'b01, 5'd0);
        bus_a.register_locked = '0;
        bus_a.unit_done       = '0;
        bus_b.register_locked = '0;
        bus_b.unit_done       = '0;
        step();
        step();
        settle();
        check("rst_busy", 64'(bus_a.unit_busy), 64'h0);
        check("rst_stall", 64'(bus_a.stall_count), 64'h0);
        check("rst_hold", 64'(bus_a.hold), 64'h0);
        reset = 1'b0;
        step();

        // First ALU op, rd=5, issues on port 0 with lock.
        op_a(1'b1, 2'b01, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
        settle();
        check("t1_vld", 64'(bus_a.unit_vld), 64'h1);
        check("t1_lock_en", 64'(bus_a.register_lock_en), 64'h1);
        check("t1_lock", 64'(bus_a.register_lock[0]), 64'd5);
        check("t1_hold", 64'(bus_a.hold), 64'h0);
        step();

        // Second op goes to port 1 by round robin.
        op_a(1'b1, 2'b01, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        settle();
        check("t2_busy", 64'(bus_a.unit_busy), 64'h1);
        check("t2_vld", 64'(bus_a.unit_vld), 64'h2);
        check("t2_lock", 64'(bus_a.register_lock[1]), 64'd6);
        step();

        // Third op: both busy, hold twice.
        op_a(1'b1, 2'b01, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        settle();
        check("t3_busy", 64'(bus_a.unit_busy), 64'h3);
        check("t3_hold", 64'(bus_a.hold), 64'h1);
        check("t3_vld", 64'(bus_a.unit_vld), 64'h0);
        step();
        settle();
        check("t3_stall1", 64'(bus_a.stall_count), 64'd1);
        step();
        bus_a.unit_done = 2'b01;
        settle();
        check("t3_stall2", 64'(bus_a.stall_count), 64'd2);
        check("t3_done_vld", 64'(bus_a.unit_vld), 64'h1);
        check("t3_done_hold", 64'(bus_a.hold), 64'h0);
        step();

        // Done and issue same cycle kept port 0 busy; now drain both.
        op_a(1'b0, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus_a.unit_done = 2'b11;
        settle();
        check("t3_busy_keep", 64'(bus_a.unit_busy), 64'h3);
        step();
        bus_a.unit_done = 2'b00;

        // RAW on rs1=7 for three cycles.
        op_a(1'b1, 2'b01, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        bus_a.register_locked = 32'h0000_0080;
        settle();
        check("raw_busy0", 64'(bus_a.unit_busy), 64'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) settle();
            check("raw_hold", 64'(bus_a.hold), 64'h1);
            check("raw_vld", 64'(bus_a.unit_vld), 64'h0);
            step();
        end
        bus_a.register_locked = '0;
        settle();
        check("raw_stall", 64'(bus_a.stall_count), 64'd5);
        check("raw_issue", 64'(bus_a.unit_vld), 64'h2);
        check("raw_lock", 64'(bus_a.register_lock[1]), 64'd8);
        step();

        // rs2=x0 with locked[0] set never hazards; rd=x0 never locks.
        op_a(1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        bus_a.register_locked = 32'h0000_0001;
        settle();
        check("x0_hold", 64'(bus_a.hold), 64'h0);
        check("x0_vld", 64'(bus_a.unit_vld), 64'h1);
        check("x0_lock_en", 64'(bus_a.register_lock_en), 64'h0);
        step();
        bus_a.register_locked = '0;

        // Reset with both ports busy and a valid instruction pending.
        op_a(1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        reset = 1'b1;
        settle();
        check("rst2_busy_before", 64'(bus_a.unit_busy), 64'h3);
        check("rst2_vld", 64'(bus_a.unit_vld), 64'h0);
        check("rst2_lock_en", 64'(bus_a.register_lock_en), 64'h0);
        check("rst2_hold", 64'(bus_a.hold), 64'h0);
        step();
        reset = 1'b0;
        settle();
        check("rst2_busy", 64'(bus_a.unit_busy), 64'h0);
        check("rst2_stall", 64'(bus_a.stall_count), 64'h0);
        check("rst2_issue", 64'(bus_a.unit_vld), 64'h1);
        check("rst2_lock", 64'(bus_a.register_lock[0]), 64'd3);
        step();
        op_a(1'b0, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus_a.unit_done = 2'b01;
        step();
        bus_a.unit_done = 2'b00;

        // WAW: rd=9 pending, sources free; rr_ptr is 1.
        op_a(1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        bus_a.register_locked = 32'h0000_0200;
        settle();
`ifdef RISCV_EXU_ISSUE_WAW_EN
        check("waw_hold", 64'(bus_a.hold), 64'h1);
        check("waw_vld", 64'(bus_a.unit_vld), 64'h0);
`else
        check("waw_hold", 64'(bus_a.hold), 64'h0);
        check("waw_vld", 64'(bus_a.unit_vld), 64'h2);
        check("waw_lock", 64'(bus_a.register_lock[1]), 64'd9);
`endif
        step();
        op_a(1'b0, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus_a.register_locked = '0;
        settle();
`ifdef RISCV_EXU_ISSUE_WAW_EN
        check("waw_stall", 64'(bus_a.stall_count), 64'd1);
        check("waw_busy", 64'(bus_a.unit_busy), 64'h0);
`else
        check("waw_stall", 64'(bus_a.stall_count), 64'd0);
        check("waw_busy", 64'(bus_a.unit_busy), 64'h2);
`endif
        step();

        // Instance B: MUL/DIV only on port 1.
        op_b(1'b1, 2'b10, 5'd11);
        settle();
        check("mul_first", 64'(bus_b.unit_vld), 64'h2);
        step();
        op_b(1'b1, 2'b10, 5'd12);
        settle();
        check("mul_busy", 64'(bus_b.unit_busy), 64'h2);
        check("mul_hold", 64'(bus_b.hold), 64'h1);
        check("mul_vld0", 64'(bus_b.unit_vld), 64'h0);
        step();
        bus_b.unit_done = 2'b10;
        settle();
        check("mul_done_vld", 64'(bus_b.unit_vld), 64'h2);
        check("mul_done_hold", 64'(bus_b.hold), 64'h0);
        check("mul_lock", 64'(bus_b.register_lock[1]), 64'd12);
        step();
        bus_b.unit_done = 2'b00;
        op_b(1'b0, 2'b10, 5'd0);
        settle();
        check("mul_stall", 64'(bus_b.stall_count), 64'd1);
        check("mul_busy_end", 64'(bus_b.unit_busy), 64'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
